load_ram_seq_ctrl: RTL and testbench
====================================

Name: load_ram_seq_ctrl

Overview:
Sequencer for the RAM-load datapath. It launches the FRAM and FLASH load FSMs together and supervises them with a watchdog timeout and bounded retry. It reports a single sticky done/error result with a cause code. It sits between the board init logic and the two load FSMs.

Parameters:
TIMEOUT_CYC, 1000000, cycles allowed per attempt for both FSMs to finish (must be >= 2)
TMO_W, 20, width of the timeout counter (2^TMO_W > TIMEOUT_CYC)
MAX_RETRY, 2, retries after the first failed attempt (0..15)
GAP_CYC, 16, idle cycles between a failed attempt and the next launch (>= 1)

Ports:
sys_clk  in  1  system clock; all logic is on the rising edge
glbl_rst  in  1  synchronous reset, active-high
load_start  in  1  request pulse; accepted only in IDLE, DONE or FAIL
fram_fsm_start  out  1  one-cycle launch pulse to the FRAM load FSM
flash_fsm_start  out  1  one-cycle launch pulse to the FLASH load FSM
fram_fsm_done  in  1  FRAM FSM completion pulse
fram_fsm_error  in  1  FRAM FSM error pulse or level
flash_fsm_done  in  1  FLASH FSM completion pulse
flash_fsm_error  in  1  FLASH FSM error pulse or level
load_ram_busy  out  1  high in START, WAIT and GAP
load_ram_done  out  1  sticky success flag
load_ram_error  out  1  sticky final-failure flag
err_code  out  3  cause of the last failed attempt: [0] FRAM error, [1] FLASH error, [2] timeout
retry_cnt  out  4  number of retries used in the current or last load

Behaviour:
- Reset: state IDLE; all outputs 0; internal done latches and counters 0. Reset asserted mid-load aborts the load on the next edge and emits no further start pulses.
- All outputs are registered. Done and error inputs are ignored outside WAIT.
- IDLE, DONE or FAIL with load_start=1:
  - go to START;
  - clear load_ram_done, load_ram_error, err_code and retry_cnt.
  - load_start in any other state is ignored.
- START (1 cycle):
  - fram_fsm_start=flash_fsm_start=1 for exactly this cycle;
  - clear done latches and timer;
  - go to WAIT.
  - Start pulses appear 1 cycle after the accepted load_start.
- WAIT:
  - the timer increments every cycle;
  - fram_fsm_done and flash_fsm_done set their own sticky latches, and both may arrive in any order or in the same cycle.
  - Evaluation each cycle uses the current inputs plus the latches, in this priority order:
    1. Any error input high -> fail. err_code[0]=fram_fsm_error, err_code[1]=flash_fsm_error, err_code[2]=0.
    2. Both done, whether latched or arriving this cycle -> DONE. load_ram_done=1 on the next edge, i.e. 1 cycle after the last done.
    3. Timer == TIMEOUT_CYC-1 -> fail with err_code=3'b100.
  - Error and the final done in the same cycle count as a failure.
- Fail handling:
  - If retry_cnt < MAX_RETRY, increment retry_cnt and go to GAP.
  - Otherwise go to FAIL and set load_ram_error=1.
- GAP: count GAP_CYC cycles with no start pulses, then go to START. The next launch pulse comes GAP_CYC+1 cycles after the failing cycle.
- DONE: load_ram_done=1 and busy=0; hold until an accepted load_start.
- FAIL: load_ram_error=1, err_code and retry_cnt frozen, busy=0; hold until an accepted load_start.
- load_ram_done and load_ram_error are never 1 together.
- With MAX_RETRY=0, the first failure goes directly to FAIL.

Test Plan:
- Both FSMs succeed (load_start at cycle 0; fram_fsm_done at 5, flash_fsm_done at 9) -> start pulses at cycle 1 only; load_ram_done=1 from cycle 10; err_code=0; retry_cnt=0.
- flash_fsm_error at cycle 4 of attempts 1, 2 and 3 (MAX_RETRY=2) -> exactly 3 start pulse pairs, each GAP_CYC+1 cycles after the failure; then load_ram_error=1, err_code=3'b010, retry_cnt=2, busy=0.
- Timeout (TIMEOUT_CYC=20, MAX_RETRY=0, only fram_fsm_done arrives) -> load_ram_error=1 one cycle after WAIT cycle 19; err_code=3'b100.
- Same-cycle events: flash_fsm_done and fram_fsm_error in the cycle after fram's done is already latched, MAX_RETRY=0 -> FAIL with err_code=3'b001 and load_ram_done stays 0. Separately, both dones in the same cycle -> DONE.
- Recovery and robustness:
  - Fail on attempt 1, succeed on attempt 2 -> load_ram_done=1, retry_cnt=1, err_code=3'b010 (last failure retained).
  - load_start pulsed during WAIT -> ignored, no extra start pulse.
  - glbl_rst during WAIT -> all outputs 0 next cycle; a later done input produces no effect.

Source files
------------

// File: rtl/load_ram_seq_ctrl_if.sv
// Handshake bundle between the RAM-load sequencer, board init logic and
// the FRAM / FLASH load FSMs. master = sequencer side, slave = its peers.
interface load_ram_seq_ctrl_if;
  logic       load_start;
  logic       fram_fsm_start;
  logic       flash_fsm_start;
  logic       fram_fsm_done;
  logic       fram_fsm_error;
  logic       flash_fsm_done;
  logic       flash_fsm_error;
  logic       load_ram_busy;
  logic       load_ram_done;
  logic       load_ram_error;
  logic [2:0] err_code;
  logic [3:0] retry_cnt;

  modport master (
    input  load_start, fram_fsm_done, fram_fsm_error, flash_fsm_done, flash_fsm_error,
    output fram_fsm_start, flash_fsm_start, load_ram_busy, load_ram_done,
           load_ram_error, err_code, retry_cnt
  );

  modport slave (
    output load_start, fram_fsm_done, fram_fsm_error, flash_fsm_done, flash_fsm_error,
    input  fram_fsm_start, flash_fsm_start, load_ram_busy, load_ram_done,
           load_ram_error, err_code, retry_cnt
  );
endinterface

// File: rtl/load_ram_seq_ctrl.sv
// RAM-load sequencer: launches FRAM and FLASH load FSMs together, watches
// them with a per-attempt watchdog, retries a bounded number of times with
// an idle gap, and reports a sticky done/error result plus cause code.
module load_ram_seq_ctrl #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TMO_W       = 20,
  parameter int MAX_RETRY   = 2,
  parameter int GAP_CYC     = 16
) (
  input  logic                sys_clk,
  input  logic                glbl_rst,
  load_ram_seq_ctrl_if.master bus
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_GAP, S_DONE, S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             fram_dn_q, fram_dn_d;
  logic             flash_dn_q, flash_dn_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic [3:0]       retry_q, retry_d;

  logic             fram_all, flash_all, any_err, fail;

  // State and registered outputs; reset aborts any load in flight.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      gap_q      <= '0;
      fram_dn_q  <= 1'b0;
      flash_dn_q <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      gap_q      <= gap_d;
      fram_dn_q  <= fram_dn_d;
      flash_dn_q <= flash_dn_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      retry_q    <= retry_d;
    end
  end

  // Next-state and next-output logic; outputs are computed from state_d so
  // the launch pulse and flags line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    gap_d      = gap_q;
    fram_dn_d  = fram_dn_q;
    flash_dn_d = flash_dn_q;
    start_d    = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    code_d     = code_q;
    retry_d    = retry_q;
    fail       = 1'b0;
    // A done arriving this cycle counts the same as one already latched.
    fram_all   = fram_dn_q  | bus.fram_fsm_done;
    flash_all  = flash_dn_q | bus.flash_fsm_done;
    any_err    = bus.fram_fsm_error | bus.flash_fsm_error;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (bus.load_start) begin
          state_d = S_START;
          start_d = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = '0;
          retry_d = '0;
        end
      end
      S_START: begin
        state_d    = S_WAIT;
        tmr_d      = '0;
        fram_dn_d  = 1'b0;
        flash_dn_d = 1'b0;
      end
      S_WAIT: begin
        tmr_d      = tmr_q + 1'b1;
        fram_dn_d  = fram_all;
        flash_dn_d = flash_all;
        // Error beats completion, completion beats the watchdog.
        if (any_err) begin
          fail   = 1'b1;
          code_d = {1'b0, bus.flash_fsm_error, bus.fram_fsm_error};
        end else if (fram_all && flash_all) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (tmr_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          fail   = 1'b1;
          code_d = 3'b100;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = S_START;
          start_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Failed attempt: retry after the gap while budget remains, else give up.
    if (fail) begin
      if (retry_q < 4'(MAX_RETRY)) begin
        retry_d = retry_q + 4'd1;
        gap_d   = '0;
        state_d = S_GAP;
      end else begin
        err_d   = 1'b1;
        state_d = S_FAIL;
      end
    end

    busy_d = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_GAP);
  end

  assign bus.fram_fsm_start  = start_q;
  assign bus.flash_fsm_start = start_q;
  assign bus.load_ram_busy   = busy_q;
  assign bus.load_ram_done   = done_q;
  assign bus.load_ram_error  = err_q;
  assign bus.err_code        = code_q;
  assign bus.retry_cnt       = retry_q;

endmodule

// File: tb/tb_load_ram_seq_ctrl.sv
// Bench for load_ram_seq_ctrl: two instances (MAX_RETRY=2 and 0) share one
// stimulus stream and are checked every cycle against a timeline model.
module tb_load_ram_seq_ctrl;
  localparam int TMO = 20;
  localparam int TW  = 5;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ls = 1'b0, fd = 1'b0, fe = 1'b0, gd = 1'b0, ge = 1'b0;

  always #5 clk = ~clk;

  load_ram_seq_ctrl_if ifa();
  load_ram_seq_ctrl_if ifb();

  load_ram_seq_ctrl #(.TIMEOUT_CYC(TMO), .TMO_W(TW), .MAX_RETRY(2), .GAP_CYC(GAP)) dut_a (
    .sys_clk(clk), .glbl_rst(rst), .bus(ifa.master));
  load_ram_seq_ctrl #(.TIMEOUT_CYC(TMO), .TMO_W(TW), .MAX_RETRY(0), .GAP_CYC(GAP)) dut_b (
    .sys_clk(clk), .glbl_rst(rst), .bus(ifb.master));

  assign ifa.load_start = ls;  assign ifb.load_start = ls;
  assign ifa.fram_fsm_done = fd;  assign ifb.fram_fsm_done = fd;
  assign ifa.fram_fsm_error = fe; assign ifb.fram_fsm_error = fe;
  assign ifa.flash_fsm_done = gd; assign ifb.flash_fsm_done = gd;
  assign ifa.flash_fsm_error = ge; assign ifb.flash_fsm_error = ge;

  // {fram_start, flash_start, busy, done, error, err_code, retry_cnt}
  logic [11:0] obs [2];
  assign obs[0] = {ifa.fram_fsm_start, ifa.flash_fsm_start, ifa.load_ram_busy, ifa.load_ram_done,
                   ifa.load_ram_error, ifa.err_code, ifa.retry_cnt};
  assign obs[1] = {ifb.fram_fsm_start, ifb.flash_fsm_start, ifb.load_ram_busy, ifb.load_ram_done,
                   ifb.load_ram_error, ifb.err_code, ifb.retry_cnt};

  int n_chk = 0;
  int n_fail = 0;

  // Timeline model: pulse = launch cycle, age = cycles spent waiting
  // (-1 when not waiting), gap = idle cycles still owed before relaunch.
  bit       m_pulse [2];
  int       m_age   [2];
  int       m_gap   [2];
  bit       m_fd [2], m_gd [2], m_done [2], m_err [2];
  bit [2:0] m_code  [2];
  int       m_retry [2];

  function automatic int max_retry(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit m_busy(int i);
    return m_pulse[i] || (m_age[i] >= 0) || (m_gap[i] > 0);
  endfunction

  function automatic logic [11:0] exp_vec(int i);
    return {m_pulse[i], m_pulse[i], m_busy(i), m_done[i], m_err[i], m_code[i], 4'(m_retry[i])};
  endfunction

  task automatic model_step(int i);
    bit fdn, gdn, failed;
    bit [2:0] code;
    failed = 1'b0;
    code = 3'b000;
    if (rst) begin
      m_pulse[i] = 0; m_age[i] = -1; m_gap[i] = 0; m_fd[i] = 0; m_gd[i] = 0;
      m_done[i] = 0; m_err[i] = 0; m_code[i] = 0; m_retry[i] = 0;
    end else if (!m_busy(i)) begin
      if (ls) begin
        m_done[i] = 0; m_err[i] = 0; m_code[i] = 0; m_retry[i] = 0; m_pulse[i] = 1;
      end
    end else if (m_pulse[i]) begin
      m_pulse[i] = 0; m_age[i] = 0; m_fd[i] = 0; m_gd[i] = 0;
    end else if (m_age[i] >= 0) begin
      fdn = m_fd[i] | fd;
      gdn = m_gd[i] | gd;
      if (fe || ge) begin
        failed = 1'b1; code = {1'b0, ge, fe};
      end else if (fdn && gdn) begin
        m_age[i] = -1; m_done[i] = 1;
      end else if (m_age[i] == TMO - 1) begin
        failed = 1'b1; code = 3'b100;
      end else begin
        m_age[i]++; m_fd[i] = fdn; m_gd[i] = gdn;
      end
      if (failed) begin
        m_age[i] = -1;
        m_code[i] = code;
        if (m_retry[i] < max_retry(i)) begin
          m_retry[i]++; m_gap[i] = GAP;
        end else begin
          m_err[i] = 1;
        end
      end
    end else begin
      m_gap[i]--;
      if (m_gap[i] == 0) m_pulse[i] = 1;
    end
  endtask

  // Advance the model on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic drive(input bit r, input bit l, input bit a, input bit ae, input bit b, input bit be);
    @(negedge clk);
    rst = r; ls = l; fd = a; fe = ae; gd = b; ge = be;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 1, 1, 1, 1, 1);
      if (c >= 1) begin
        for (int i = 0; i < 2; i++) begin
          n_chk++;
          if (obs[i] !== 12'h000) begin
            n_fail++; $display("FAIL reset[%0d] c=%0d got %h want 000", i, c, obs[i]);
          end
        end
      end
    end
    do_reset();
  endtask

  task automatic test_success();
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      drive(0, 0, c == 5, 0, c == 9, 0);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL success[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
      n_chk++;
      if (ifa.fram_fsm_start !== (c == 1) || ifa.load_ram_done !== (c >= 10)) begin
        n_fail++;
        $display("FAIL success_timing c=%0d got start=%b done=%b", c, ifa.fram_fsm_start, ifa.load_ram_done);
      end
    end
  endtask

  task automatic test_retry_fail();
    int last_p = -100;
    int pq[$];
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 40; c++) begin
      drive(0, 0, 0, 0, 0, c == last_p + 4);
      if (m_pulse[0]) last_p = c;
      if (ifa.fram_fsm_start === 1'b1 && ifa.flash_fsm_start === 1'b1) pq.push_back(c);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL retry[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
    if (pq.size() != 3) begin
      n_fail++; $display("FAIL retry_pulses got %0d want 3", pq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (pq[k] != 1 + k * (4 + GAP + 1)) begin
          n_fail++; $display("FAIL retry_pulse_cyc k=%0d got %0d want %0d", k, pq[k], 1 + k * (4 + GAP + 1));
        end
      end
    end
    n_chk++;
    if ({ifa.load_ram_error, ifa.err_code, ifa.retry_cnt, ifa.load_ram_busy} !== {1'b1, 3'b010, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL retry_final got err=%b code=%b retry=%0d busy=%b", ifa.load_ram_error, ifa.err_code,
               ifa.retry_cnt, ifa.load_ram_busy);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 24; c++) begin
      drive(0, 0, c == 3, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL timeout[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
      n_chk++;
      if (ifb.load_ram_error !== (c >= 22) || (c >= 22 && ifb.err_code !== 3'b100)) begin
        n_fail++; $display("FAIL timeout_edge c=%0d got err=%b code=%b", c, ifb.load_ram_error, ifb.err_code);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 7; c++) begin
      drive(0, 0, c == 3, c == 4, c == 4, 0);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL same_err[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
    if ({ifb.load_ram_error, ifb.load_ram_done, ifb.err_code} !== {1'b1, 1'b0, 3'b001}) begin
      n_fail++; $display("FAIL same_err_final got err=%b done=%b code=%b", ifb.load_ram_error,
                         ifb.load_ram_done, ifb.err_code);
    end
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      drive(0, 0, c == 3, 0, c == 3, 0);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL same_done[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
    if (ifa.load_ram_done !== 1'b1 || ifb.load_ram_done !== 1'b1) begin
      n_fail++; $display("FAIL same_done_final got a=%b b=%b want 1 1", ifa.load_ram_done, ifb.load_ram_done);
    end
  endtask

  task automatic test_recovery();
    int npulse = 0;
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 14; c++) begin
      drive(0, (c == 2) || (c == 5), c == 10, 0, c == 12, c == 3);
      if (ifa.fram_fsm_start === 1'b1) npulse++;
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL recovery[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
    n_chk++;
    if (npulse != 2 || {ifa.load_ram_done, ifa.retry_cnt, ifa.err_code} !== {1'b1, 4'd1, 3'b010}) begin
      n_fail++; $display("FAIL recovery_final got pulses=%0d done=%b retry=%0d code=%b want 2 1 1 010",
                         npulse, ifa.load_ram_done, ifa.retry_cnt, ifa.err_code);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({ifa.fram_fsm_start, ifa.load_ram_done, ifa.retry_cnt, ifa.err_code} !== {1'b1, 1'b0, 4'd0, 3'b000}) begin
      n_fail++; $display("FAIL b2b_restart got start=%b done=%b retry=%0d code=%b", ifa.fram_fsm_start,
                         ifa.load_ram_done, ifa.retry_cnt, ifa.err_code);
    end
    for (int c = 2; c <= 6; c++) begin
      drive(0, 0, c == 4, 0, c == 4, 0);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL b2b[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      drive(c == 4, 0, (c == 3) || (c == 7), 0, c == 6, 0);
      if (c >= 5) begin
        for (int i = 0; i < 2; i++) begin
          n_chk++;
          if (obs[i] !== 12'h000) begin
            n_fail++; $display("FAIL reset_mid[%0d] c=%0d got %h want 000", i, c, obs[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_vec(i)) begin
          n_fail++; $display("FAIL random[%0d] c=%0d got %h want %h", i, c, obs[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_success();
    test_retry_fail();
    test_timeout();
    test_same_cycle();
    test_recovery();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
